// File: rtl/ct_rtu_ptr_pkg.sv
// Shared definitions for the RTU 64-entry pointer manager.
// DEPTH/PTR_W/MAX_INC sizing, the {flip,ptr} pointer type and a wrap-aware add.
package ct_rtu_ptr_pkg;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned PTR_W   = 6;
    localparam int unsigned MAX_INC = 4;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned NUM_W   = 3;

    // Pointer with wrap bit; flip toggles every time ptr wraps past DEPTH-1.
    typedef struct packed {
        logic             flip;
        logic [PTR_W-1:0] ptr;
    } ptr_t;

    // {flip,ptr} + n modulo 2*DEPTH
    function automatic ptr_t ptr_add(input ptr_t p, input logic [NUM_W-1:0] n);
        logic [CNT_W-1:0] sum;
        sum = {p.flip, p.ptr} + CNT_W'(n);
        return ptr_t'(sum);
    endfunction

endpackage

// File: rtl/ct_rtu_decode_64.sv
// 6-bit binary to 64-bit one-hot decoder (purely combinational).
// Ports: bin  - binary index
//        onehot - single bit set at position bin
module ct_rtu_decode_64
    import ct_rtu_ptr_pkg::*;
(
    input  logic [PTR_W-1:0] bin,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/ct_rtu_ptr_decode_64.sv
// Create/retire pointer manager for the 64-entry RTU circular queue.
// Keeps binary pointers with wrap bits, an entry count, and registered one-hot
// copies of both pointers so downstream entry selects need no decoder.
// Ports:
//   forever_cpuclk, cpurst        - clock, synchronous active-high reset
//   x_create_vld/num              - create request (num 0 is a no-op)
//   x_retire_vld/num              - retire request (num 0 is a no-op)
//   x_flush                       - drop all un-retired entries
//   x_create_ptr/flip/ptr_expand  - create pointer, binary and one-hot
//   x_retire_ptr/flip/ptr_expand  - retire pointer, binary and one-hot
//   x_entry_cnt, x_full, x_empty  - occupancy
//   x_create_err, x_retire_err    - one-cycle reject pulses
module ct_rtu_ptr_decode_64
    import ct_rtu_ptr_pkg::*;
(
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             x_create_vld,
    input  logic [NUM_W-1:0] x_create_num,
    input  logic             x_retire_vld,
    input  logic [NUM_W-1:0] x_retire_num,
    input  logic             x_flush,
    output logic [PTR_W-1:0] x_create_ptr,
    output logic             x_create_flip,
    output logic [DEPTH-1:0] x_create_ptr_expand,
    output logic [PTR_W-1:0] x_retire_ptr,
    output logic             x_retire_flip,
    output logic [DEPTH-1:0] x_retire_ptr_expand,
    output logic [CNT_W-1:0] x_entry_cnt,
    output logic             x_full,
    output logic             x_empty,
    output logic             x_create_err,
    output logic             x_retire_err
);

    ptr_t             create_q;
    ptr_t             retire_q;
    logic [CNT_W-1:0] cnt_q;

    ptr_t             create_nxt;
    ptr_t             retire_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] free_space;
    logic             create_ok;
    logic             retire_ok;
    logic             create_rej;
    logic             retire_rej;
    logic [DEPTH-1:0] create_onehot;
    logic [DEPTH-1:0] retire_onehot;

    // Acceptance: free space is judged on the registered count, before any
    // same-cycle retire frees a slot. A create during flush is silently dropped.
    always_comb begin
        free_space = CNT_W'(DEPTH) - cnt_q;
        retire_ok  = x_retire_vld && (CNT_W'(x_retire_num) <= cnt_q);
        retire_rej = x_retire_vld && (CNT_W'(x_retire_num) >  cnt_q);
        create_ok  = x_create_vld && !x_flush && (CNT_W'(x_create_num) <= free_space);
        create_rej = x_create_vld && !x_flush && (CNT_W'(x_create_num) >  free_space);
    end

    // Next pointers/count; flush snaps create onto the post-retire pointer.
    always_comb begin
        retire_nxt = retire_q;
        create_nxt = create_q;
        cnt_nxt    = cnt_q;
        if (retire_ok) begin
            retire_nxt = ptr_add(retire_q, x_retire_num);
        end
        if (x_flush) begin
            create_nxt = retire_nxt;
            cnt_nxt    = '0;
        end else begin
            if (create_ok) begin
                create_nxt = ptr_add(create_q, x_create_num);
            end
            cnt_nxt = cnt_q
                    + (create_ok ? CNT_W'(x_create_num) : CNT_W'(0))
                    - (retire_ok ? CNT_W'(x_retire_num) : CNT_W'(0));
        end
    end

    // Decode the next pointers so the one-hot registers load alongside the binary ones.
    ct_rtu_decode_64 u_create_dec (
        .bin    (create_nxt.ptr),
        .onehot (create_onehot)
    );

    ct_rtu_decode_64 u_retire_dec (
        .bin    (retire_nxt.ptr),
        .onehot (retire_onehot)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            create_q            <= '0;
            retire_q            <= '0;
            cnt_q               <= '0;
            x_create_ptr_expand <= DEPTH'(1);
            x_retire_ptr_expand <= DEPTH'(1);
            x_full              <= 1'b0;
            x_empty             <= 1'b1;
            x_create_err        <= 1'b0;
            x_retire_err        <= 1'b0;
        end else begin
            create_q            <= create_nxt;
            retire_q            <= retire_nxt;
            cnt_q               <= cnt_nxt;
            x_create_ptr_expand <= create_onehot;
            x_retire_ptr_expand <= retire_onehot;
            x_full              <= (cnt_nxt == CNT_W'(DEPTH));
            x_empty             <= (cnt_nxt == CNT_W'(0));
            x_create_err        <= create_rej;
            x_retire_err        <= retire_rej;
        end
    end

    assign x_create_ptr  = create_q.ptr;
    assign x_create_flip = create_q.flip;
    assign x_retire_ptr  = retire_q.ptr;
    assign x_retire_flip = retire_q.flip;
    assign x_entry_cnt   = cnt_q;

endmodule

// File: tb/tb_ct_rtu_ptr_decode_64.sv
// Self-checking bench for ct_rtu_ptr_decode_64: directed scenarios plus random
// traffic, compared against a position-based queue model.
module tb_ct_rtu_ptr_decode_64;

    logic        clk;
    logic        rst;
    logic        create_vld;
    logic [2:0]  create_num;
    logic        retire_vld;
    logic [2:0]  retire_num;
    logic        flush;
    logic [5:0]  create_ptr;
    logic        create_flip;
    logic [63:0] create_expand;
    logic [5:0]  retire_ptr;
    logic        retire_flip;
    logic [63:0] retire_expand;
    logic [6:0]  entry_cnt;
    logic        full;
    logic        empty;
    logic        create_err;
    logic        retire_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: absolute positions modulo 128 (bit 6 is the wrap flag).
    int m_cpos = 0;
    int m_rpos = 0;
    int m_cerr = 0;
    int m_rerr = 0;

    ct_rtu_ptr_decode_64 dut (
        .forever_cpuclk      (clk),
        .cpurst              (rst),
        .x_create_vld        (create_vld),
        .x_create_num        (create_num),
        .x_retire_vld        (retire_vld),
        .x_retire_num        (retire_num),
        .x_flush             (flush),
        .x_create_ptr        (create_ptr),
        .x_create_flip       (create_flip),
        .x_create_ptr_expand (create_expand),
        .x_retire_ptr        (retire_ptr),
        .x_retire_flip       (retire_flip),
        .x_retire_ptr_expand (retire_expand),
        .x_entry_cnt         (entry_cnt),
        .x_full              (full),
        .x_empty             (empty),
        .x_create_err        (create_err),
        .x_retire_err        (retire_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        return (m_cpos - m_rpos + 128) % 128;
    endfunction

    task automatic model_step(input bit r, input bit cv, input int cn,
                              input bit rv, input int rn, input bit fl);
        int cnt;
        cnt = m_cnt();
        if (r) begin
            m_cpos = 0; m_rpos = 0; m_cerr = 0; m_rerr = 0;
            return;
        end
        m_rerr = (rv && rn > cnt) ? 1 : 0;
        m_cerr = (cv && !fl && cn > 64 - cnt) ? 1 : 0;
        if (rv && rn <= cnt) m_rpos = (m_rpos + rn) % 128;
        if (fl) m_cpos = m_rpos;
        else if (cv && cn <= 64 - cnt) m_cpos = (m_cpos + cn) % 128;
    endtask

    task automatic compare_all(input string tag);
        logic [63:0] one;
        int cnt;
        one = 64'd1;
        cnt = m_cnt();
        check({tag, ":cptr"},   64'(create_ptr),  64'(m_cpos % 64));
        check({tag, ":cflip"},  64'(create_flip), 64'(m_cpos / 64));
        check({tag, ":cexp"},   create_expand,    one << (m_cpos % 64));
        check({tag, ":rptr"},   64'(retire_ptr),  64'(m_rpos % 64));
        check({tag, ":rflip"},  64'(retire_flip), 64'(m_rpos / 64));
        check({tag, ":rexp"},   retire_expand,    one << (m_rpos % 64));
        check({tag, ":cnt"},    64'(entry_cnt),   64'(cnt));
        check({tag, ":full"},   64'(full),        64'(cnt == 64));
        check({tag, ":empty"},  64'(empty),       64'(cnt == 0));
        check({tag, ":cerr"},   64'(create_err),  64'(m_cerr));
        check({tag, ":rerr"},   64'(retire_err),  64'(m_rerr));
    endtask

    // Apply one cycle of inputs, clock it, then check outputs 1 time unit later.
    task automatic step(input string tag, input bit r, input bit cv, input int cn,
                        input bit rv, input int rn, input bit fl);
        rst        = r;
        create_vld = cv;
        create_num = 3'(cn);
        retire_vld = rv;
        retire_num = 3'(rn);
        flush      = fl;
        @(posedge clk);
        #1;
        model_step(r, cv, cn, rv, rn, fl);
        compare_all(tag);
    endtask

    task automatic create_n(input int n);
        int left;
        left = n;
        while (left > 0) begin
            step("fill", 0, 1, (left > 4) ? 4 : left, 0, 0, 0);
            left -= (left > 4) ? 4 : left;
        end
    endtask

    task automatic retire_n(input int n);
        int left;
        left = n;
        while (left > 0) begin
            step("drain", 0, 0, 0, 1, (left > 4) ? 4 : left, 0);
            left -= (left > 4) ? 4 : left;
        end
    endtask

    initial begin
        rst = 1'b1; create_vld = 1'b0; create_num = '0;
        retire_vld = 1'b0; retire_num = '0; flush = 1'b0;
        @(negedge clk);

        // Reset state
        step("reset", 1, 0, 0, 0, 0, 0);
        check("reset_exp", create_expand, 64'h1);

        // Fill to full, then overflow attempt
        for (int i = 0; i < 16; i++) step("fill16", 0, 1, 4, 0, 0, 0);
        check("full_flag", 64'(full), 64'd1);
        check("full_cflip", 64'(create_flip), 64'd1);
        step("over", 0, 1, 1, 0, 0, 0);
        check("over_err", 64'(create_err), 64'd1);

        // Retire wrap: rptr 62, count 10, retire 3
        retire_n(62);
        create_n(8);
        step("rwrap", 0, 0, 0, 1, 3, 0);
        check("rwrap_ptr", 64'(retire_ptr), 64'd1);
        check("rwrap_exp", retire_expand, 64'h2);
        check("rwrap_cnt", 64'(entry_cnt), 64'd7);

        // Simultaneous create/retire; then create rejected at count 63
        create_n(3);
        step("both", 0, 1, 2, 1, 3, 0);
        check("both_cnt", 64'(entry_cnt), 64'd9);
        create_n(54);
        step("both63", 0, 1, 2, 1, 4, 0);
        check("both63_cnt", 64'(entry_cnt), 64'd59);
        check("both63_cerr", 64'(create_err), 64'd1);

        // Flush: count 20 at rptr 5, flush with retire 2 and a create
        step("rst2", 1, 0, 0, 0, 0, 0);
        create_n(5);
        retire_n(5);
        create_n(20);
        step("flush", 0, 1, 3, 1, 2, 1);
        check("flush_cptr", 64'(create_ptr), 64'd7);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_cerr", 64'(create_err), 64'd0);
        step("post_flush", 0, 0, 0, 1, 1, 0);
        check("post_flush_rerr", 64'(retire_err), 64'd1);

        // num = 0 with vld is a no-op
        step("zero", 0, 1, 0, 1, 0, 0);

        // Reset mid-stream with count 30
        create_n(30);
        step("midrst", 1, 1, 3, 1, 2, 0);
        check("midrst_cnt", 64'(entry_cnt), 64'd0);
        check("midrst_rexp", retire_expand, 64'h1);

        // Random traffic with shifting bias to visit both full and empty
        for (int i = 0; i < 3000; i++) begin
            bit cv, rv, fl, r;
            int bias;
            bias = ((i / 200) % 2 == 0) ? 75 : 35;
            cv = ($urandom_range(99) < bias);
            rv = ($urandom_range(99) < (110 - bias));
            fl = ($urandom_range(99) < 2);
            r  = ($urandom_range(999) < 3);
            step("rand", r, cv, int'($urandom_range(4)), rv, int'($urandom_range(4)), fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
